// File: rtl/aes_pkg.sv
// Shared AES constants: inverse S-box table and the decipher FSM state type.
// Single table source for both encrypt and decrypt sides.
package aes_pkg;

   typedef logic [0:0] state_t;

   localparam state_t ST_IDLE   = 1'b0;
   localparam state_t ST_ACTIVE = 1'b1;

   localparam logic [7:0] INV_SBOX [256] = '{
      8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
      8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
      8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
      8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
      8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
      8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
      8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
      8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
      8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
      8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
      8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
      8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
      8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
      8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
      8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
      8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
   };

endpackage

// File: rtl/aes_decipher_if.sv
// Byte-stream handshake bundle for aes_decipher: seed pulse, ciphertext in, plaintext out.
interface aes_decipher_if;
   logic       new_message;
   logic [7:0] key;
   logic       valid_in;
   logic [7:0] data_in;
   logic       in_ready;
   logic [7:0] data_out;
   logic       valid_out;
   logic       out_ready;

   modport master (
      output new_message, key, valid_in, data_in, out_ready,
      input  in_ready, data_out, valid_out
   );

   modport slave (
      input  new_message, key, valid_in, data_in, out_ready,
      output in_ready, data_out, valid_out
   );
endinterface

// File: rtl/aes_keystream.sv
// Keystream generator: 8-bit index counter feeding the inverse S-box lookup.
module aes_keystream
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [7:0] seed,
   input  logic       load,
   input  logic       advance,
   output logic [7:0] ks_byte
);

   logic [7:0] index;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         index <= 8'h00;
      end else if (load) begin
         index <= seed;
      end else if (advance) begin
         index <= index + 8'd1;
      end
   end

   assign ks_byte = INV_SBOX[index];

endmodule

// File: rtl/aes_decipher.sv
// Stream decipher: XORs each accepted byte with an inverse-S-box keystream.
// Optional macro AES_DECIPHER_CNT_EN adds the byte_count output.
module aes_decipher
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             reset_n,
   aes_decipher_if.slave    bus
`ifdef AES_DECIPHER_CNT_EN
   ,
   output logic [15:0]      byte_count
`endif
);

   // state     | meaning
   // ST_IDLE   | no seed since reset; nothing accepted
   // ST_ACTIVE | seeded; bytes accepted when output slot free

   state_t     state;
   logic       accept;
   logic [7:0] ks_byte;

   assign bus.in_ready = (state == ST_ACTIVE) && !bus.new_message &&
                         (!bus.valid_out || bus.out_ready);
   assign accept       = bus.valid_in && bus.in_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else if (bus.new_message) begin
         state <= ST_ACTIVE;
      end
   end

   aes_keystream u_keystream (
      .clk     (clk),
      .reset_n (reset_n),
      .seed    (bus.key),
      .load    (bus.new_message),
      .advance (accept),
      .ks_byte (ks_byte)
   );

   // Output slot: a pending byte survives new_message until the sink takes it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.valid_out <= 1'b0;
         bus.data_out  <= 8'h00;
      end else if (accept) begin
         bus.valid_out <= 1'b1;
         bus.data_out  <= bus.data_in ^ ks_byte;
      end else if (bus.out_ready) begin
         bus.valid_out <= 1'b0;
         bus.data_out  <= 8'h00;
      end
   end

`ifdef AES_DECIPHER_CNT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         byte_count <= 16'h0000;
      end else if (bus.new_message) begin
         byte_count <= 16'h0000;
      end else if (accept && (byte_count != 16'hFFFF)) begin
         byte_count <= byte_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_aes_decipher.sv
// Scoreboard bench for aes_decipher; reference inverse S-box derived from GF(2^8) arithmetic.
// Define AES_DECIPHER_CNT_EN to also exercise byte_count.
module tb_aes_decipher;

   logic clk;
   logic reset_n;

   aes_decipher_if bus ();

`ifdef AES_DECIPHER_CNT_EN
   logic [15:0] byte_count;
`endif

   aes_decipher dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
`ifdef AES_DECIPHER_CNT_EN
      ,
      .byte_count (byte_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] inv_ref [256];
   logic [7:0] exp_q [$];

   // reference state: seeded flag, message key, bytes accepted, output slot occupied
   bit         m_seeded  = 0;
   logic [7:0] m_key     = 8'h00;
   int         m_n       = 0;
   bit         m_pending = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      end
      return p;
   endfunction

   function automatic logic [7:0] rol8(input logic [7:0] v, input int s);
      return (v << s) | (v >> (8 - s));
   endfunction

   task automatic build_ref();
      for (int b = 0; b < 256; b++) begin
         logic [7:0] inv = 8'h00;
         logic [7:0] s;
         for (int c = 1; c < 256; c++)
            if (gf_mul(8'(b), 8'(c)) == 8'h01) inv = 8'(c);
         s = inv ^ rol8(inv, 1) ^ rol8(inv, 2) ^ rol8(inv, 3) ^ rol8(inv, 4) ^ 8'h63;
         inv_ref[s] = 8'(b);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      m_seeded  = 0;
      m_key     = 8'h00;
      m_n       = 0;
      m_pending = 0;
      exp_q.delete();
   endtask

   // Reference model: sees the same inputs the DUT samples at each rising edge.
   initial begin
      forever begin
         bit acc;
         bit rdy;
         @(posedge clk);
         if (reset_n) begin
            rdy = m_seeded && !bus.new_message && (!m_pending || bus.out_ready);
            acc = bus.valid_in && rdy;
            if (acc) begin
               exp_q.push_back(bus.data_in ^ inv_ref[8'(m_key + m_n)]);
               if (m_n < 65535) m_n++;
            end
            if (bus.new_message) begin
               m_seeded = 1;
               m_key    = bus.key;
               m_n      = 0;
            end
            if (acc) m_pending = 1;
            else if (bus.out_ready) m_pending = 0;
         end
      end
   end

   // Monitor: compares DUT outputs against the model mid-cycle.
   initial begin
      forever begin
         bit rdy;
         @(negedge clk);
         rdy = m_seeded && !bus.new_message && (!m_pending || bus.out_ready);
         chk("in_ready", bus.in_ready, rdy);
         chk("valid_out", bus.valid_out, m_pending);
         if (m_pending) begin
            if (exp_q.size() == 0) begin
               chk("scoreboard_underflow_valid_out", bus.valid_out, 0);
            end else begin
               chk("data_out", bus.data_out, exp_q[0]);
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end else begin
            chk("data_out_idle_zero", bus.data_out, 8'h00);
         end
`ifdef AES_DECIPHER_CNT_EN
         chk("byte_count", byte_count, 32'(m_n));
`endif
      end
   end

   initial begin
      logic [7:0] held;
      reset_n         = 1'b0;
      bus.new_message = 1'b0;
      bus.key         = 8'h00;
      bus.valid_in    = 1'b0;
      bus.data_in     = 8'h00;
      bus.out_ready   = 1'b1;
      build_ref();
      clear_model();
      tick();
      tick();
      reset_n = 1'b1;

      // unseeded: offers ignored
      bus.valid_in = 1'b1;
      bus.data_in  = 8'h33;
      repeat (3) begin
         @(negedge clk);
         chk("idle_in_ready", bus.in_ready, 0);
         chk("idle_valid_out", bus.valid_out, 0);
         tick();
      end

      // offer during new_message is refused
      bus.new_message = 1'b1;
      bus.key         = 8'h00;
      bus.data_in     = 8'h52;
      @(negedge clk);
      chk("nm_in_ready", bus.in_ready, 0);
      tick();

      // key 0x00: 0x52, 0x09 -> 0x00, 0x00 back-to-back
      bus.new_message = 1'b0;
      bus.data_in     = 8'h52;
      tick();
      bus.data_in = 8'h09;
      @(negedge clk);
      chk("k00_first_valid", bus.valid_out, 1);
      chk("k00_first_data", bus.data_out, 8'h00);
      tick();
      bus.valid_in = 1'b0;
      @(negedge clk);
      chk("k00_second_valid", bus.valid_out, 1);
      chk("k00_second_data", bus.data_out, 8'h00);
      tick();
      @(negedge clk);
      chk("k00_drained", bus.valid_out, 0);

      // wrap: key 0xFF, 0x7D, 0x52 -> 0x00, 0x00
      bus.new_message = 1'b1;
      bus.key         = 8'hFF;
      tick();
      bus.new_message = 1'b0;
      bus.valid_in    = 1'b1;
      bus.data_in     = 8'h7D;
      tick();
      bus.data_in = 8'h52;
      @(negedge clk);
      chk("wrap_first_data", bus.data_out, 8'h00);
      tick();
      bus.valid_in = 1'b0;
      @(negedge clk);
      chk("wrap_second_data", bus.data_out, 8'h00);
      tick();

      // backpressure for 3 cycles with valid_in held
      bus.new_message = 1'b1;
      bus.key         = 8'h10;
      tick();
      bus.new_message = 1'b0;
      bus.valid_in    = 1'b1;
      bus.data_in     = 8'hA1;
      tick();
      bus.out_ready = 1'b0;
      bus.data_in   = 8'hB2;
      held = 8'hA1 ^ inv_ref[8'h10];
      repeat (3) begin
         @(negedge clk);
         chk("bp_in_ready", bus.in_ready, 0);
         chk("bp_frozen_data", bus.data_out, held);
         tick();
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_ready", bus.in_ready, 1);
      tick();
      bus.valid_in = 1'b0;
      @(negedge clk);
      chk("bp_next_data", bus.data_out, 8'hB2 ^ inv_ref[8'h11]);
      tick();
      tick();

`ifdef AES_DECIPHER_CNT_EN
      bus.new_message = 1'b1;
      bus.key         = 8'h3C;
      tick();
      bus.new_message = 1'b0;
      bus.valid_in    = 1'b1;
      repeat (5) begin
         bus.data_in = 8'($urandom);
         tick();
      end
      bus.valid_in = 1'b0;
      @(negedge clk);
      chk("cnt_five", byte_count, 16'd5);
      bus.new_message = 1'b1;
      tick();
      bus.new_message = 1'b0;
      @(negedge clk);
      chk("cnt_cleared", byte_count, 16'd0);
      tick();
`endif

      // reset while an output is pending
      bus.new_message = 1'b1;
      bus.key         = 8'h77;
      tick();
      bus.new_message = 1'b0;
      bus.valid_in    = 1'b1;
      bus.data_in     = 8'h5A;
      tick();
      reset_n = 1'b0;
      clear_model();
      #1;
      chk("rst_valid_out", bus.valid_out, 0);
      chk("rst_data_out", bus.data_out, 8'h00);
      tick();
      reset_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_ignored", bus.in_ready, 0);
         tick();
      end

      // randomized traffic with occasional reseed and reset
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ($urandom_range(0, 599) == 0) begin
            reset_n = 1'b0;
            clear_model();
            tick();
            reset_n = 1'b1;
         end
         bus.new_message = ($urandom_range(0, 99) < 3);
         bus.key         = 8'($urandom);
         bus.valid_in    = ($urandom_range(0, 99) < 75);
         bus.data_in     = 8'($urandom);
         bus.out_ready   = ($urandom_range(0, 99) < 70);
         tick();
      end

      bus.new_message = 1'b0;
      bus.valid_in    = 1'b0;
      bus.out_ready   = 1'b1;
      repeat (4) tick();
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/aes_decipher.md
AES_DECIPHER -- requirements
Module: aes_decipher

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port new_message  input  1  one-cycle pulse; reseeds keystream; carries no data.
REQ-004 SHALL have port key  input  8  seed, sampled only when new_message=1.
REQ-005 SHALL have port valid_in  input  1  ciphertext byte valid.
REQ-006 SHALL have port data_in  input  8  ciphertext byte.
REQ-007 SHALL have port in_ready  output  1  block accepts data_in this cycle.
REQ-008 SHALL have port data_out  output  8  plaintext byte, registered.
REQ-009 SHALL have port valid_out  output  1  data_out valid, registered.
REQ-010 SHALL have port out_ready  input  1  sink accepts data_out this cycle.

Function
REQ-011 SHALL implement FSM with states IDLE (no seed yet) and ACTIVE (seeded).
REQ-012 SHALL transition IDLE->ACTIVE and ACTIVE->ACTIVE on new_message=1, loading index counter with key.
REQ-013 SHALL drive in_ready = (state==ACTIVE) && !new_message && (!valid_out || out_ready), combinationally.
REQ-014 SHALL accept a byte only when valid_in && in_ready; bytes offered in IDLE or on a new_message cycle are not accepted.
REQ-015 SHALL decrypt the n-th accepted byte after new_message (n=1,2,...) as data_in XOR inv_sbox[(key+n-1) mod 256].
REQ-016 SHALL advance the 8-bit index counter by 1 per accepted byte only, wrapping 0xFF->0x00; idle cycles and stall cycles do not advance it.
REQ-017 SHALL present the result on data_out/valid_out exactly 1 cycle after acceptance.
REQ-018 SHALL hold data_out and valid_out stable while valid_out=1 and out_ready=0.
REQ-019 SHALL clear valid_out after a cycle with valid_out && out_ready and no new acceptance; with a simultaneous acceptance, SHALL load the new byte (full throughput, one byte/cycle).
REQ-020 SHALL, on new_message while an output is pending, keep that pending output until consumed; new_message never flushes data_out.
REQ-021 SHALL drive data_out=0x00 whenever valid_out=0.

Reset
REQ-022 SHALL, on reset_n=0 at any time including mid-message, immediately force state=IDLE, index=0x00, valid_out=0, data_out=0x00, optional byte_count=0.
REQ-023 SHALL require a new_message after reset before accepting any byte.

Configuration
REQ-024 SHALL, with macro AES_DECIPHER_CNT_EN defined, add output port byte_count (16 bits): accepted bytes since last new_message, cleared to 0 on new_message, saturating at 0xFFFF.
REQ-025 SHALL, without AES_DECIPHER_CNT_EN, omit byte_count port and its logic; all other behaviour identical.

Structure
REQ-026 SHALL take the 256x8 inverse S-box constant and the FSM state typedef from shared package aes_pkg, the single table source used by both encrypt and decrypt sides.
REQ-027 SHALL place index counter plus table lookup in sub-module aes_keystream (inputs seed, load, advance; output 8-bit keystream byte).

Verification
REQ-028 SHALL cover: reset, new_message key=0x00, then bytes 0x52,0x09 back-to-back with out_ready=1 -> data_out 0x00,0x00 on consecutive cycles, 1-cycle latency.
REQ-029 SHALL cover wrap: key=0xFF, bytes 0x7D,0x52 -> 0x00,0x00 (index 0xFF then 0x00).
REQ-030 SHALL cover backpressure: out_ready=0 for 3 cycles with valid_in held -> in_ready=0, data_out frozen, index not advanced; after release stream continues without loss or duplication.
REQ-031 SHALL cover IDLE and new_message cycles: valid_in=1 with no prior seed or during new_message -> in_ready=0, no output.
REQ-032 SHALL cover reset mid-message with valid_out=1 -> valid_out=0, data_out=0x00 immediately; subsequent bytes ignored until new_message.
REQ-033 SHALL cover, with AES_DECIPHER_CNT_EN, 5 accepted bytes -> byte_count=5, then new_message -> byte_count=0.
